// File: rtl/des_pkg.sv
// Shared DES constants: permutation tables, S-boxes, rotation schedule and controller states.
// Tables use DES numbering (position 1 = most significant bit).
package des_pkg;

   localparam int BLK_W    = 64;
   localparam int HALF_W   = 32;
   localparam int KEY56_W  = 56;
   localparam int SUBKEY_W = 48;

   typedef enum logic [1:0] {IDLE, ROUND, DONE} state_t;

   localparam int IP_T [64] = '{
      58, 50, 42, 34, 26, 18, 10, 2,  60, 52, 44, 36, 28, 20, 12, 4,
      62, 54, 46, 38, 30, 22, 14, 6,  64, 56, 48, 40, 32, 24, 16, 8,
      57, 49, 41, 33, 25, 17,  9, 1,  59, 51, 43, 35, 27, 19, 11, 3,
      61, 53, 45, 37, 29, 21, 13, 5,  63, 55, 47, 39, 31, 23, 15, 7};

   localparam int FP_T [64] = '{
      40, 8, 48, 16, 56, 24, 64, 32,  39, 7, 47, 15, 55, 23, 63, 31,
      38, 6, 46, 14, 54, 22, 62, 30,  37, 5, 45, 13, 53, 21, 61, 29,
      36, 4, 44, 12, 52, 20, 60, 28,  35, 3, 43, 11, 51, 19, 59, 27,
      34, 2, 42, 10, 50, 18, 58, 26,  33, 1, 41,  9, 49, 17, 57, 25};

   localparam int PC1_T [56] = '{
      57, 49, 41, 33, 25, 17,  9,   1, 58, 50, 42, 34, 26, 18,
      10,  2, 59, 51, 43, 35, 27,  19, 11,  3, 60, 52, 44, 36,
      63, 55, 47, 39, 31, 23, 15,   7, 62, 54, 46, 38, 30, 22,
      14,  6, 61, 53, 45, 37, 29,  21, 13,  5, 28, 20, 12,  4};

   localparam int PC2_T [48] = '{
      14, 17, 11, 24,  1,  5,   3, 28, 15,  6, 21, 10,
      23, 19, 12,  4, 26,  8,  16,  7, 27, 20, 13,  2,
      41, 52, 31, 37, 47, 55,  30, 40, 51, 45, 33, 48,
      44, 49, 39, 56, 34, 53,  46, 42, 50, 36, 29, 32};

   localparam int E_T [48] = '{
      32,  1,  2,  3,  4,  5,   4,  5,  6,  7,  8,  9,
       8,  9, 10, 11, 12, 13,  12, 13, 14, 15, 16, 17,
      16, 17, 18, 19, 20, 21,  20, 21, 22, 23, 24, 25,
      24, 25, 26, 27, 28, 29,  28, 29, 30, 31, 32,  1};

   localparam int P_T [32] = '{
      16,  7, 20, 21, 29, 12, 28, 17,   1, 15, 23, 26,  5, 18, 31, 10,
       2,  8, 24, 14, 32, 27,  3,  9,  19, 13, 30,  6, 22, 11,  4, 25};

   // Each S-box is 64 nibbles, entry (row*16+col) counted from the most significant nibble.
   localparam logic [255:0] SBOX [8] = '{
      {64'hE4D12FB83A6C5907, 64'h0F74E2D1A6CB9538, 64'h41E8D62BFC973A50, 64'hFC8249175B3EA06D},
      {64'hF18E6B34972DC05A, 64'h3D47F28EC01A69B5, 64'h0E7BA4D158C6932F, 64'hD8A13F42B67C05E9},
      {64'hA09E63F51DC7B428, 64'hD709346A285ECBF1, 64'hD6498F30B12C5AE7, 64'h1AD069874FE3B52C},
      {64'h7DE3069A1285BC4F, 64'hD8B56F03472C1AE9, 64'hA690CB7DF13E5284, 64'h3F06A1D8945BC72E},
      {64'h2C417AB6853FD0E9, 64'hEB2C47D150FA3986, 64'h421BAD78F9C5630E, 64'hB8C71E2D6F09A453},
      {64'hC1AF92680D34E75B, 64'hAF427C9561DE0B38, 64'h9EF528C3704A1DB6, 64'h432C95FABE17608D},
      {64'h4B2EF08D3C975A61, 64'hD0B7491AE35C2F86, 64'h14BDC37EAF680592, 64'h6BD814A7950FE23C},
      {64'hD2846FB1A93E50C7, 64'h1FD8A374C56B0E92, 64'h7B419CE206ADF358, 64'h21E74A8DFC90356B}};

   localparam int SHIFT [16] = '{1, 1, 2, 2, 2, 2, 2, 2, 1, 2, 2, 2, 2, 2, 2, 1};

endpackage

// File: rtl/des_key_sched.sv
// On-the-fly DES key schedule: PC1 load, per-round rotate (left to encrypt, right to decrypt), PC2 subkey.
module des_key_sched
   import des_pkg::*;
(
   input  logic                clk,
   input  logic                rst,
   input  logic                load,
   input  logic                step,
   input  logic                decrypt,
   input  logic [3:0]          cnt,
   input  logic [BLK_W-1:0]    key,
   output logic [SUBKEY_W-1:0] subkey
);

   localparam int CD_HALF = KEY56_W / 2;

   logic [KEY56_W-1:0] cd_reg;
   logic [KEY56_W-1:0] cd_rot;
   logic [KEY56_W-1:0] pc1_out;
   logic [CD_HALF-1:0] c_cur, d_cur, c_rot, d_rot;
   logic               two;
   logic [7:0]         key_parity_unused;

   genvar gi;
   generate
      for (gi = 0; gi < KEY56_W; gi++) begin : g_pc1
         assign pc1_out[KEY56_W-1-gi] = key[BLK_W-PC1_T[gi]];
      end
      for (gi = 0; gi < 8; gi++) begin : g_par
         assign key_parity_unused[gi] = key[8*gi];
      end
   endgenerate

   assign c_cur = cd_reg[KEY56_W-1:CD_HALF];
   assign d_cur = cd_reg[CD_HALF-1:0];

   // Decrypt walks the schedule backwards, so it undoes the shift of the mirrored round.
   assign two = (SHIFT[decrypt ? 4'd15 - cnt : cnt] == 2);

   always_comb begin
      if (decrypt) begin
         c_rot = two ? {c_cur[1:0], c_cur[27:2]} : {c_cur[0], c_cur[27:1]};
         d_rot = two ? {d_cur[1:0], d_cur[27:2]} : {d_cur[0], d_cur[27:1]};
      end else begin
         c_rot = two ? {c_cur[25:0], c_cur[27:26]} : {c_cur[26:0], c_cur[27]};
         d_rot = two ? {d_cur[25:0], d_cur[27:26]} : {d_cur[26:0], d_cur[27]};
      end
   end

   assign cd_rot = {c_rot, d_rot};

   // Encrypt uses the freshly rotated halves; decrypt uses the held halves before rotating.
   generate
      for (gi = 0; gi < SUBKEY_W; gi++) begin : g_pc2
         assign subkey[SUBKEY_W-1-gi] = decrypt ? cd_reg[KEY56_W-PC2_T[gi]]
                                                : cd_rot[KEY56_W-PC2_T[gi]];
      end
   endgenerate

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         cd_reg <= '0;
      end else if (load) begin
         cd_reg <= pc1_out;
      end else if (step) begin
         cd_reg <= cd_rot;
      end
   end

endmodule

// File: rtl/round.sv
// One combinational DES Feistel round: out_left = in_right, out_right = in_left ^ f(in_right, subkey).
module round
   import des_pkg::*;
(
   input  logic [SUBKEY_W-1:0] subkey,
   input  logic [HALF_W-1:0]   in_left,
   input  logic [HALF_W-1:0]   in_right,
   output logic [HALF_W-1:0]   out_left,
   output logic [HALF_W-1:0]   out_right
);

   logic [SUBKEY_W-1:0] expanded;
   logic [SUBKEY_W-1:0] mixed;
   logic [HALF_W-1:0]   sbox_out;
   logic [HALF_W-1:0]   f_out;

   genvar gi;
   generate
      for (gi = 0; gi < SUBKEY_W; gi++) begin : g_expand
         assign expanded[SUBKEY_W-1-gi] = in_right[HALF_W-E_T[gi]];
      end

      // Six-bit group selects row {b1,b6} and column b2..b5; ~index converts to a right-shift count.
      for (gi = 0; gi < 8; gi++) begin : g_sbox
         logic [5:0] six;
         logic [5:0] entry;
         assign six   = mixed[SUBKEY_W-1-6*gi -: 6];
         assign entry = {six[5], six[0], six[4:1]};
         assign sbox_out[HALF_W-1-4*gi -: 4] = 4'(SBOX[gi] >> {~entry, 2'b00});
      end

      for (gi = 0; gi < HALF_W; gi++) begin : g_pbox
         assign f_out[HALF_W-1-gi] = sbox_out[HALF_W-P_T[gi]];
      end
   endgenerate

   assign mixed     = expanded ^ subkey;
   assign out_left  = in_right;
   assign out_right = in_left ^ f_out;

endmodule

// File: rtl/des_iter_ctrl.sv
// Iterative DES controller: one Feistel round per cycle, 16 cycles per block, valid/ready on both sides.
// Optional key parity check enabled by defining DES_KEY_PARITY_CHECK_EN.
module des_iter_ctrl
   import des_pkg::*;
#(
   parameter int BYPASS_IPFP = 0
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [BLK_W-1:0] in_block,
   input  logic [BLK_W-1:0] in_key,
   input  logic             in_decrypt,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [BLK_W-1:0] out_block,
   output logic             busy,
   output logic [3:0]       round_idx,
   output logic             key_err
);

   state_t              state_reg, state_next;
   logic [3:0]          cnt_reg;
   logic [HALF_W-1:0]   l_reg, r_reg;
   logic                decrypt_reg;
   logic [BLK_W-1:0]    out_block_reg;
   logic                out_valid_reg;
   logic                accept, step, finish, key_ok;
   logic [BLK_W-1:0]    ip_out, fp_in, fp_out;
   logic [SUBKEY_W-1:0] subkey;
   logic [HALF_W-1:0]   rnd_left, rnd_right;

   genvar gi;
   generate
      if (BYPASS_IPFP != 0) begin : g_raw
         assign ip_out = in_block;
         assign fp_out = fp_in;
      end else begin : g_perm
         for (gi = 0; gi < BLK_W; gi++) begin : g_bit
            assign ip_out[BLK_W-1-gi] = in_block[BLK_W-IP_T[gi]];
            assign fp_out[BLK_W-1-gi] = fp_in[BLK_W-FP_T[gi]];
         end
      end
   endgenerate

`ifdef DES_KEY_PARITY_CHECK_EN
   logic [7:0] byte_odd;
   logic       key_err_reg;
   generate
      for (gi = 0; gi < 8; gi++) begin : g_parity
         assign byte_odd[gi] = ^in_key[8*gi +: 8];
      end
   endgenerate
   assign key_ok = &byte_odd;

   // A rejected key leaves the FSM in IDLE; only the sticky flag records it.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         key_err_reg <= 1'b0;
      end else if (state_reg == IDLE && in_valid && !key_ok) begin
         key_err_reg <= 1'b1;
      end
   end
   assign key_err = key_err_reg;
`else
   assign key_ok  = 1'b1;
   assign key_err = 1'b0;
`endif

   des_key_sched u_key_sched (
      .clk     (clk),
      .rst     (rst),
      .load    (accept),
      .step    (step),
      .decrypt (decrypt_reg),
      .cnt     (cnt_reg),
      .key     (in_key),
      .subkey  (subkey)
   );

   round u_round (
      .subkey    (subkey),
      .in_left   (l_reg),
      .in_right  (r_reg),
      .out_left  (rnd_left),
      .out_right (rnd_right)
   );

   // Final swap: the last round's halves are exchanged before FP.
   assign fp_in = {rnd_right, rnd_left};

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_reg <= IDLE;
      end else begin
         state_reg <= state_next;
      end
   end

   always_comb begin
      state_next = state_reg;
      in_ready   = 1'b0;
      accept     = 1'b0;
      step       = 1'b0;
      finish     = 1'b0;
      case (state_reg)
         IDLE: begin
            in_ready = 1'b1;
            if (in_valid && key_ok) begin
               accept     = 1'b1;
               state_next = ROUND;
            end
         end
         ROUND: begin
            step = 1'b1;
            if (cnt_reg == 4'd15) begin
               finish     = 1'b1;
               state_next = DONE;
            end
         end
         DONE: begin
            if (out_ready) state_next = IDLE;
         end
         default: state_next = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         cnt_reg       <= '0;
         l_reg         <= '0;
         r_reg         <= '0;
         decrypt_reg   <= 1'b0;
         out_block_reg <= '0;
         out_valid_reg <= 1'b0;
      end else begin
         if (accept) begin
            l_reg       <= ip_out[BLK_W-1:HALF_W];
            r_reg       <= ip_out[HALF_W-1:0];
            decrypt_reg <= in_decrypt;
            cnt_reg     <= '0;
         end else if (step) begin
            l_reg   <= rnd_left;
            r_reg   <= rnd_right;
            cnt_reg <= cnt_reg + 4'd1;
         end
         if (finish) begin
            out_block_reg <= fp_out;
            out_valid_reg <= 1'b1;
         end else if (out_valid_reg && out_ready) begin
            out_valid_reg <= 1'b0;
         end
      end
   end

   assign out_valid = out_valid_reg;
   assign out_block = out_block_reg;
   assign busy      = (state_reg != IDLE);
   assign round_idx = (state_reg == ROUND) ? cnt_reg : 4'd0;

endmodule

// File: tb/tb_des_iter_ctrl.sv
// Bench for des_iter_ctrl: known-answer vectors, random blocks against a behavioural DES model,
// backpressure, mid-block reset and (with DES_KEY_PARITY_CHECK_EN) key parity rejection.
module tb_des_iter_ctrl;
   import des_pkg::*;

   logic        clk = 1'b0;
   logic        rst = 1'b0;
   logic        in_valid = 1'b0;
   logic        in_ready;
   logic [63:0] in_block = '0;
   logic [63:0] in_key = '0;
   logic        in_decrypt = 1'b0;
   logic        out_valid;
   logic        out_ready = 1'b0;
   logic [63:0] out_block;
   logic        busy;
   logic [3:0]  round_idx;
   logic        key_err;

   int n_cmp = 0;
   int n_mis = 0;

   des_iter_ctrl #(.BYPASS_IPFP(0)) dut (
      .clk        (clk),
      .rst        (rst),
      .in_valid   (in_valid),
      .in_ready   (in_ready),
      .in_block   (in_block),
      .in_key     (in_key),
      .in_decrypt (in_decrypt),
      .out_valid  (out_valid),
      .out_ready  (out_ready),
      .out_block  (out_block),
      .busy       (busy),
      .round_idx  (round_idx),
      .key_err    (key_err)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_mis++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   // ---------------- behavioural DES model ----------------
   function automatic logic pick(input logic [63:0] x, input int w, input int pos);
      logic [63:0] t;
      t = x >> (w - pos);
      return t[0];
   endfunction

   function automatic logic [31:0] f_ref(input logic [31:0] r, input logic [47:0] k);
      logic [47:0]  e;
      logic [31:0]  s, p;
      logic [5:0]   six;
      logic [255:0] t;
      int           idx;
      e = '0;
      for (int i = 0; i < 48; i++) e = {e[46:0], pick({32'd0, r}, 32, E_T[i])};
      e = e ^ k;
      s = '0;
      for (int j = 0; j < 8; j++) begin
         six = 6'(e >> (42 - 6 * j));
         idx = 16 * (2 * int'(six[5]) + int'(six[0])) + int'(six[4:1]);
         t   = SBOX[j] >> (4 * (63 - idx));
         s   = {s[27:0], t[3:0]};
      end
      p = '0;
      for (int i = 0; i < 32; i++) p = {p[30:0], pick({32'd0, s}, 32, P_T[i])};
      return p;
   endfunction

   function automatic logic [63:0] des_ref(input logic [63:0] key, input logic [63:0] blk, input logic dec);
      logic [63:0] x;
      logic [55:0] cd, tc, td;
      logic [27:0] c, d;
      logic [47:0] ks [16];
      logic [47:0] kk;
      logic [31:0] l, r, nl;
      int          sh;
      cd = '0;
      for (int i = 0; i < 56; i++) cd = {cd[54:0], pick(key, 64, PC1_T[i])};
      c  = cd[55:28];
      d  = cd[27:0];
      sh = 0;
      // Subkey n uses the original halves rotated left by the cumulative shift total.
      for (int n = 0; n < 16; n++) begin
         sh += SHIFT[n];
         tc = {c, c} << sh;
         td = {d, d} << sh;
         cd = {tc[55:28], td[55:28]};
         kk = '0;
         for (int i = 0; i < 48; i++) kk = {kk[46:0], pick({8'd0, cd}, 56, PC2_T[i])};
         ks[n] = kk;
      end
      x = '0;
      for (int i = 0; i < 64; i++) x = {x[62:0], pick(blk, 64, IP_T[i])};
      l = x[63:32];
      r = x[31:0];
      for (int n = 0; n < 16; n++) begin
         kk = dec ? ks[15 - n] : ks[n];
         nl = r;
         r  = l ^ f_ref(r, kk);
         l  = nl;
      end
      x = '0;
      for (int i = 0; i < 64; i++) x = {x[62:0], pick({r, l}, 64, FP_T[i])};
      return x;
   endfunction

   function automatic logic [63:0] odd_par(input logic [63:0] k);
      logic [63:0] res;
      logic [7:0]  b;
      res = '0;
      for (int i = 7; i >= 0; i--) begin
         b    = 8'(k >> (8 * i));
         b[0] = ~^b[7:1];
         res  = {res[55:0], b};
      end
      return res;
   endfunction

   // ---------------- transaction task ----------------
   task automatic run_block(input logic [63:0] key, input logic [63:0] blk, input logic dec,
                            input logic [63:0] exp, input int hold, output logic [63:0] got);
      int lat;
      @(negedge clk);
      check("in_ready_idle", 64'(in_ready), 64'd1);
      in_valid   = 1'b1;
      in_key     = key;
      in_block   = blk;
      in_decrypt = dec;
      @(negedge clk);
      in_valid   = 1'b0;
      in_key     = {$urandom, $urandom};
      in_block   = {$urandom, $urandom};
      in_decrypt = ~dec;
      check("busy_after_accept", 64'(busy), 64'd1);
      check("round_idx_first", 64'(round_idx), 64'd0);
      for (lat = 1; lat <= 40; lat++) begin
         @(negedge clk);
         if (out_valid) break;
         if (lat < 16) check("round_idx", 64'(round_idx), 64'(lat));
         check("in_ready_round", 64'(in_ready), 64'd0);
      end
      check("latency", 64'(lat), 64'd16);
      check("out_block", out_block, exp);
      got = out_block;
      for (int h = 0; h < hold; h++) begin
         in_valid = h[0];
         in_block = {$urandom, $urandom};
         @(negedge clk);
         check("hold_out_valid", 64'(out_valid), 64'd1);
         check("hold_in_ready", 64'(in_ready), 64'd0);
         check("hold_out_block", out_block, exp);
      end
      in_valid  = 1'b0;
      out_ready = 1'b1;
      @(negedge clk);
      out_ready = 1'b0;
      check("out_valid_cleared", 64'(out_valid), 64'd0);
      check("in_ready_back", 64'(in_ready), 64'd1);
      check("busy_cleared", 64'(busy), 64'd0);
      if (hold > 0) begin
         @(negedge clk);
         check("pulses_ignored", 64'(busy), 64'd0);
      end
      $display("blk key=%h in=%h dec=%0d out=%h exp=%h lat=%0d", key, blk, dec, got, exp, lat);
   endtask

   initial begin
      #2000000;
      $display("FAIL watchdog expired observed=timeout expected=finish");
      $fatal(1, "watchdog");
   end

   initial begin
      logic [63:0] got, key, blk, ct;
      logic        dec;
      int          k;

      // reset state
      repeat (2) @(negedge clk);
      check("rst_in_ready", 64'(in_ready), 64'd1);
      check("rst_out_valid", 64'(out_valid), 64'd0);
      check("rst_out_block", out_block, 64'd0);
      check("rst_busy", 64'(busy), 64'd0);
      check("rst_round_idx", 64'(round_idx), 64'd0);
      check("rst_key_err", 64'(key_err), 64'd0);
      rst = 1'b1;

      // known-answer vectors
      run_block(64'h133457799BBCDFF1, 64'h0123456789ABCDEF, 1'b0, 64'h85E813540F0AB405, 0, got);
      run_block(64'h133457799BBCDFF1, 64'h85E813540F0AB405, 1'b1, 64'h0123456789ABCDEF, 0, got);
      run_block(64'h0E329232EA6D0D73, 64'h8787878787878787, 1'b0, 64'h0000000000000000, 0, got);
      check("model_kat", des_ref(64'h133457799BBCDFF1, 64'h0123456789ABCDEF, 1'b0), 64'h85E813540F0AB405);

      // backpressure
      run_block(64'h0E329232EA6D0D73, 64'h8787878787878787, 1'b0, 64'h0000000000000000, 5, got);

      // reset in the middle of round 7
      @(negedge clk);
      in_valid = 1'b1;
      in_key   = 64'h133457799BBCDFF1;
      in_block = 64'h0123456789ABCDEF;
      in_decrypt = 1'b0;
      @(negedge clk);
      in_valid = 1'b0;
      for (k = 0; k < 40; k++) begin
         if (round_idx == 4'd7) break;
         @(negedge clk);
      end
      check("reach_round7", 64'(k < 40), 64'd1);
      rst = 1'b0;
      #1;
      check("abort_out_valid", 64'(out_valid), 64'd0);
      check("abort_in_ready", 64'(in_ready), 64'd1);
      check("abort_busy", 64'(busy), 64'd0);
      check("abort_round_idx", 64'(round_idx), 64'd0);
      @(negedge clk);
      rst = 1'b1;
      run_block(64'h133457799BBCDFF1, 64'h0123456789ABCDEF, 1'b0, 64'h85E813540F0AB405, 0, got);

      // random blocks against the model, then a model-independent round trip
      for (int i = 0; i < 8; i++) begin
         key = odd_par({$urandom, $urandom});
         blk = {$urandom, $urandom};
         dec = 1'($urandom_range(0, 1));
         run_block(key, blk, dec, des_ref(key, blk, dec), (i == 3) ? 2 : 0, got);
      end
      for (int i = 0; i < 3; i++) begin
         key = odd_par({$urandom, $urandom});
         blk = {$urandom, $urandom};
         run_block(key, blk, 1'b0, des_ref(key, blk, 1'b0), 0, ct);
         run_block(key, ct, 1'b1, blk, 0, got);
      end

      // key with bad parity in the last byte
`ifdef DES_KEY_PARITY_CHECK_EN
      @(negedge clk);
      in_valid = 1'b1;
      in_key   = 64'h133457799BBCDFF0;
      in_block = 64'h0123456789ABCDEF;
      in_decrypt = 1'b0;
      @(negedge clk);
      in_valid = 1'b0;
      check("parity_key_err", 64'(key_err), 64'd1);
      check("parity_in_ready", 64'(in_ready), 64'd1);
      check("parity_busy", 64'(busy), 64'd0);
      k = 0;
      for (int i = 0; i < 20; i++) begin
         @(negedge clk);
         if (out_valid || busy) k++;
      end
      check("parity_no_output", 64'(k), 64'd0);
      run_block(64'h133457799BBCDFF1, 64'h0123456789ABCDEF, 1'b0, 64'h85E813540F0AB405, 0, got);
      check("parity_sticky", 64'(key_err), 64'd1);
`else
      run_block(64'h133457799BBCDFF0, 64'h0123456789ABCDEF, 1'b0, 64'h85E813540F0AB405, 0, got);
      check("parity_ignored_key_err", 64'(key_err), 64'd0);
`endif

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
      $finish;
   end

endmodule
